alu_req_scheduler: RTL and testbench

- Shares the single combinational 16-bit ALU (Z = X + Y, flags S, Cr, Ze, P, O) among NREQ requesters.
- Requesters are arbitrated round-robin with a valid/ready handshake.
- Granted operands are registered and held stable on the ALU for WAIT_CYC cycles. The result, flags and requester ID are then returned on a valid/ready response port.
- Operand switching activity (Hamming distance between successive operand pairs) is accumulated for the power-estimation datapath.

---
 rtl/alu_sched_pkg.sv | 29 ++
 rtl/alu16.sv | 27 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/alu_req_scheduler.sv | 167 ++++++++++++++++
 tb/tb_alu_req_scheduler.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sched_pkg.sv
// Shared widths, flag positions, scheduler state encoding and the popcount helper
// used by the ALU request scheduler.
package alu_sched_pkg;

    localparam int DATA_W = 16;
    localparam int FLAG_W = 5;

    localparam int FLG_S  = 4;
    localparam int FLG_CR = 3;
    localparam int FLG_ZE = 2;
    localparam int FLG_P  = 1;
    localparam int FLG_O  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [5:0] popcount16(input logic [DATA_W-1:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < DATA_W; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/alu16.sv
// Combinational 16-bit adder ALU: Z = X + Y with sign, carry, zero, parity
// (XOR of all result bits) and signed-overflow flags.
module alu16
    import alu_sched_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic [DATA_W-1:0] z,
    output logic [FLAG_W-1:0] flags
);

    logic [DATA_W:0] sum_s;

    assign sum_s = {1'b0, x} + {1'b0, y};
    assign z     = sum_s[DATA_W-1:0];

    // Flag vector assembled from the raw sum
    always_comb begin
        flags         = '0;
        flags[FLG_S]  = sum_s[DATA_W-1];
        flags[FLG_CR] = sum_s[DATA_W];
        flags[FLG_ZE] = (sum_s[DATA_W-1:0] == 16'h0000);
        flags[FLG_P]  = ^sum_s[DATA_W-1:0];
        flags[FLG_O]  = (x[DATA_W-1] == y[DATA_W-1]) && (sum_s[DATA_W-1] != x[DATA_W-1]);
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 (mod N) for the first
// active request and returns it one-hot and as an index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    // Rotating priority search; the first hit wins
    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx] && !gnt_any) begin
                gnt_any  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end else begin
            end
        end
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one ALU among NREQ requesters, with a valid/ready
// response port and saturating operand-toggle accounting.
module alu_req_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int WAIT_CYC = 1,
    parameter int CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DATA_W-1:0] req_x,
    input  logic [NREQ*DATA_W-1:0] req_y,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [DATA_W-1:0]      rsp_z,
    output logic [FLAG_W-1:0]      rsp_flags,
    output logic                   busy,
    input  logic                   toggle_clr,
    output logic [CNT_W-1:0]       toggle_cnt
);

    state_t              state_r, state_nxt_s;
    logic [IDW-1:0]      rr_ptr_r, id_r, gnt_idx_s;
    logic [DATA_W-1:0]   op_x_r, op_y_r, prev_x_r, prev_y_r, sel_x_s, sel_y_s, alu_z_s;
    logic [FLAG_W-1:0]   alu_flags_s;
    logic [3:0]          wait_r;
    logic [NREQ-1:0]     gnt_s, ready_s;
    logic                gnt_any_s, accept_s;
    logic                rsp_valid_r;
    logic [IDW-1:0]      rsp_id_r;
    logic [DATA_W-1:0]   rsp_z_r;
    logic [FLAG_W-1:0]   rsp_flags_r;
    logic [CNT_W-1:0]    toggle_cnt_r, toggle_nxt_s;
    logic [6:0]          inc_s;
    logic [CNT_W:0]      sum_s;

    rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .gnt_any (gnt_any_s)
    );

    alu16 u_alu (
        .x     (op_x_r),
        .y     (op_y_r),
        .z     (alu_z_s),
        .flags (alu_flags_s)
    );

    // Grants are only offered while idle and out of reset
    always_comb begin
        if ((state_r == IDLE) && rst_n && gnt_any_s) begin
            ready_s = gnt_s;
        end else begin
            ready_s = '0;
        end
    end

    assign accept_s = |(req_valid & ready_s);
    assign sel_x_s  = req_x[int'(gnt_idx_s)*DATA_W +: DATA_W];
    assign sel_y_s  = req_y[int'(gnt_idx_s)*DATA_W +: DATA_W];
    assign inc_s    = {1'b0, popcount16(sel_x_s ^ prev_x_r)} + {1'b0, popcount16(sel_y_s ^ prev_y_r)};
    assign sum_s    = {1'b0, toggle_cnt_r} + (CNT_W+1)'(inc_s);

    // Toggle counter update: clear wins over accumulation, sum saturates at all-ones
    always_comb begin
        toggle_nxt_s = toggle_cnt_r;
        if (accept_s) begin
            if (toggle_clr) begin
                toggle_nxt_s = CNT_W'(inc_s);
            end else if (sum_s[CNT_W]) begin
                toggle_nxt_s = '1;
            end else begin
                toggle_nxt_s = sum_s[CNT_W-1:0];
            end
        end else if (toggle_clr) begin
            toggle_nxt_s = '0;
        end else begin
            toggle_nxt_s = toggle_cnt_r;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = EXEC;
                else          state_nxt_s = IDLE;
            end
            EXEC: begin
                if (wait_r == 4'd0) state_nxt_s = RESP;
                else                state_nxt_s = EXEC;
            end
            RESP: begin
                if (rsp_ready) state_nxt_s = IDLE;
                else           state_nxt_s = RESP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register, operand latch, result capture and toggle bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            rr_ptr_r     <= IDW'(NREQ-1);
            id_r         <= '0;
            op_x_r       <= '0;
            op_y_r       <= '0;
            prev_x_r     <= '0;
            prev_y_r     <= '0;
            wait_r       <= 4'd0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= '0;
            rsp_z_r      <= '0;
            rsp_flags_r  <= '0;
            toggle_cnt_r <= '0;
        end else begin
            state_r      <= state_nxt_s;
            toggle_cnt_r <= toggle_nxt_s;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_x_r   <= sel_x_s;
                        op_y_r   <= sel_y_s;
                        prev_x_r <= sel_x_s;
                        prev_y_r <= sel_y_s;
                        id_r     <= gnt_idx_s;
                        rr_ptr_r <= gnt_idx_s;
                        wait_r   <= 4'(WAIT_CYC-1);
                    end
                end
                EXEC: begin
                    if (wait_r == 4'd0) begin
                        rsp_z_r     <= alu_z_s;
                        rsp_flags_r <= alu_flags_s;
                        rsp_id_r    <= id_r;
                        rsp_valid_r <= 1'b1;
                    end else begin
                        wait_r <= wait_r - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid_r <= 1'b0;
                end
                default: rsp_valid_r <= 1'b0;
            endcase
        end
    end

    assign req_ready  = ready_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_z      = rsp_z_r;
    assign rsp_flags  = rsp_flags_r;
    assign busy       = (state_r != IDLE);
    assign toggle_cnt = toggle_cnt_r;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler: scoreboard of expected responses plus an
// independent toggle model; a second instance exercises a narrow saturating counter.
module tb_alu_req_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [63:0] req_x, req_y;
    logic [3:0]  req_ready;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_z;
    logic [4:0]  rsp_flags;
    logic        busy, toggle_clr;
    logic [31:0] toggle_cnt;

    logic [1:0]  b_req_valid, b_req_ready;
    logic [31:0] b_req_x, b_req_y;
    logic        b_rsp_valid, b_rsp_ready, b_busy, b_toggle_clr;
    logic [0:0]  b_rsp_id;
    logic [15:0] b_rsp_z;
    logic [4:0]  b_rsp_flags;
    logic [5:0]  b_toggle_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] z;
        logic [4:0]  f;
    } exp_t;
    exp_t sb[$];

    logic [15:0] m_prev_x, m_prev_y;
    logic [32:0] m_cnt;

    always #5 clk = ~clk;

    alu_req_scheduler #(.NREQ(4), .IDW(2), .WAIT_CYC(1), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_flags(rsp_flags), .busy(busy),
        .toggle_clr(toggle_clr), .toggle_cnt(toggle_cnt)
    );

    alu_req_scheduler #(.NREQ(2), .IDW(1), .WAIT_CYC(2), .CNT_W(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_x(b_req_x), .req_y(b_req_y),
        .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_id(b_rsp_id), .rsp_z(b_rsp_z), .rsp_flags(b_rsp_flags), .busy(b_busy),
        .toggle_clr(b_toggle_clr), .toggle_cnt(b_toggle_cnt)
    );

    function automatic logic [4:0] ref_flags(input logic [15:0] x, input logic [15:0] y);
        logic [16:0] s;
        logic [15:0] z;
        s = {1'b0, x} + {1'b0, y};
        z = s[15:0];
        return {z[15], s[16], (z == 16'h0000), ^z, (x[15] == y[15]) && (z[15] != x[15])};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev_x = 16'h0000;
        m_prev_y = 16'h0000;
        m_cnt    = 33'd0;
        sb.delete();
    endtask

    task automatic model_accept(input int g, input logic [15:0] x, input logic [15:0] y, input logic clr);
        logic [32:0] inc;
        exp_t e;
        inc = 33'($countones(x ^ m_prev_x) + $countones(y ^ m_prev_y));
        if (clr) m_cnt = inc;
        else if (m_cnt + inc > 33'h0_FFFF_FFFF) m_cnt = 33'h0_FFFF_FFFF;
        else m_cnt = m_cnt + inc;
        m_prev_x = x;
        m_prev_y = y;
        e.id = 2'(g);
        e.z  = x + y;
        e.f  = ref_flags(x, y);
        sb.push_back(e);
    endtask

    task automatic drive_req(input logic [3:0] v, input int who, input logic [15:0] x, input logic [15:0] y);
        req_valid = v;
        req_x[16*who +: 16] = x;
        req_y[16*who +: 16] = y;
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_id"}, 64'(rsp_id), 64'(e.id));
            chk({tag, "_z"}, 64'(rsp_z), 64'(e.z));
            chk({tag, "_flags"}, 64'(rsp_flags), 64'(e.f));
        end
    endtask

    // Waits (bounded) for a grant, checks it and the toggle count, then takes the accept edge.
    task automatic expect_accept(input int g, input string tag, output int waited);
        logic [3:0] oh;
        int cnt;
        cnt = 0;
        oh = 4'b0001 << g;
        #1;
        while (req_ready == 4'b0000 && cnt < 10) begin
            if (rsp_valid && rsp_ready) pop_cmp({tag, "_rsp"});
            @(posedge clk); #1;
            cnt++;
        end
        waited = cnt;
        chk({tag, "_gnt"}, 64'(req_ready), 64'(oh));
        model_accept(g, req_x[16*g +: 16], req_y[16*g +: 16], toggle_clr);
        @(posedge clk); #1;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_tcnt"}, 64'(toggle_cnt), 64'(m_cnt));
    endtask

    task automatic collect_rsp(input int hold, input string tag);
        int cnt;
        logic [15:0] z0;
        cnt = 0;
        while (!rsp_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        z0 = rsp_z;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
            chk({tag, "_hold_z"}, 64'(rsp_z), 64'(z0));
            chk({tag, "_hold_ready"}, 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        pop_cmp(tag);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, 64'(rsp_valid), 64'd0);
    endtask

    task automatic b_op(input logic [15:0] x, input logic [15:0] y, input logic clr,
                        input logic [5:0] exp_cnt, input string tag);
        logic [15:0] ez;
        ez = x + y;
        b_req_valid = 2'b01;
        b_req_x[15:0] = x;
        b_req_y[15:0] = y;
        b_toggle_clr = clr;
        #1;
        chk({tag, "_gnt"}, 64'(b_req_ready), 64'd1);
        @(posedge clk); #1;
        b_req_valid = 2'b00;
        b_toggle_clr = 1'b0;
        chk({tag, "_tcnt"}, 64'(b_toggle_cnt), 64'(exp_cnt));
        chk({tag, "_lat0"}, 64'(b_rsp_valid), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_lat1"}, 64'(b_rsp_valid), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_lat2"}, 64'(b_rsp_valid), 64'd1);
        chk({tag, "_z"}, 64'(b_rsp_z), 64'(ez));
        chk({tag, "_flags"}, 64'(b_rsp_flags), 64'(ref_flags(x, y)));
        b_rsp_ready = 1'b1;
        @(posedge clk); #1;
        b_rsp_ready = 1'b0;
        chk({tag, "_drop"}, 64'(b_rsp_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0;
        req_valid = 4'hF; req_x = '0; req_y = '0;
        rsp_ready = 1'b0; toggle_clr = 1'b0;
        b_req_valid = 2'b00; b_req_x = '0; b_req_y = '0;
        b_rsp_ready = 1'b0; b_toggle_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tcnt", 64'(toggle_cnt), 64'd0);
        chk("rst_z", 64'(rsp_z), 64'd0);
        chk("rst_id", 64'(rsp_id), 64'd0);
        chk("rst_flags", 64'(rsp_flags), 64'd0);
        req_valid = 4'h0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single request from requester 0
        drive_req(4'b0001, 0, 16'h4F86, 16'h1234);
        expect_accept(0, "t1", w);
        chk("t1_same_cycle", 64'(w), 64'd0);
        chk("t1_tcnt13", 64'(toggle_cnt), 64'd13);
        chk("t1_not_yet", 64'(rsp_valid), 64'd0);
        req_valid = 4'h0;
        @(posedge clk); #1;
        chk("t1_lat", 64'(rsp_valid), 64'd1);
        collect_rsp(0, "t1");
        chk("t1_z_kept", 64'(rsp_z), 64'h61BA);
        chk("t1_idle", 64'(busy), 64'd0);

        // Follow-on from requester 2
        drive_req(4'b0100, 2, 16'hAAAA, 16'h5555);
        expect_accept(2, "t2", w);
        chk("t2_tcnt28", 64'(toggle_cnt), 64'd28);
        req_valid = 4'h0;
        collect_rsp(0, "t2");
        chk("t2_z", 64'(rsp_z), 64'hFFFF);
        chk("t2_id", 64'(rsp_id), 64'd2);

        // Fresh reset, then all four requesters contend with rsp_ready held high
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            drive_req(4'h0, i, 16'h1357 * 16'(i + 1), 16'hF0F0 ^ 16'(i * 16'h0111));
        end
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            expect_accept(k % 4, "t3", w);
            if (k > 0) chk("t3_gap", 64'(w), 64'd2);
        end
        req_valid = 4'h0;
        collect_rsp(0, "t3_last");

        // Stalled response with another requester waiting
        drive_req(4'b0010, 1, 16'h4F87, 16'h8000);
        expect_accept(1, "t4", w);
        req_valid = 4'b1000;
        collect_rsp(5, "t4");
        chk("t4_z", 64'(rsp_z), 64'hCF87);
        chk("t4_next_gnt", 64'(req_ready), 64'b1000);
        expect_accept(3, "t4b", w);
        chk("t4b_immediate", 64'(w), 64'd0);
        req_valid = 4'h0;
        collect_rsp(0, "t4b");

        // Reset while in EXEC abandons the operation
        drive_req(4'b0001, 0, 16'h1234, 16'h1111);
        expect_accept(0, "t5", w);
        rst_n = 1'b0;
        req_valid = 4'hF;
        model_reset();
        @(posedge clk); #1;
        chk("t5_valid", 64'(rsp_valid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_tcnt", 64'(toggle_cnt), 64'd0);
        chk("t5_z", 64'(rsp_z), 64'd0);
        chk("t5_flags", 64'(rsp_flags), 64'd0);
        chk("t5_id", 64'(rsp_id), 64'd0);
        chk("t5_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        expect_accept(0, "t5b", w);
        req_valid = 4'h0;
        collect_rsp(0, "t5b");

        // Narrow counter: saturation, hold, clear with accept, standalone clear
        b_op(16'hFFFF, 16'hFFFF, 1'b0, 6'd32, "t6a");
        b_op(16'h0000, 16'h0000, 1'b0, 6'd63, "t6b");
        b_op(16'hFFFF, 16'hFFFF, 1'b0, 6'd63, "t6c");
        b_op(16'h0000, 16'h0000, 1'b1, 6'd32, "t6d");
        b_op(16'hFFFF, 16'hFFFF, 1'b0, 6'd63, "t6e");
        b_toggle_clr = 1'b1;
        @(posedge clk); #1;
        b_toggle_clr = 1'b0;
        chk("t6_clr", 64'(b_toggle_cnt), 64'd0);
        b_op(16'hFFFF, 16'hFFFF, 1'b0, 6'd0, "t6f");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
